// File: rtl/num_syst_multi.sv
// num_syst_multi: push-button triggered serial radix converter driving
// DIGITS active-low 7-segment displays (hex / decimal / octal).
module num_syst_multi #(
    parameter int WIDTH       = 8,
    parameter int DIGITS      = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  key_trans_n,
    input  logic                  key_clr_n,
    input  logic [1:0]            mode,
    input  logic [WIDTH-1:0]      value,
    output logic [7*DIGITS-1:0]   seg_out,
    output logic                  overflow,
    output logic                  busy,
    output logic                  done
);

    // Accumulator must hold every displayed nibble and every BCD digit WIDTH bits can produce.
    localparam int ACCW_DISP = 4 * DIGITS;
    localparam int ACCW_CONV = 4 * (WIDTH / 3 + 1);
    localparam int ACCW      = (ACCW_DISP > ACCW_CONV) ? ACCW_DISP : ACCW_CONV;
    localparam int NIB       = ACCW / 4;
    localparam int CW        = $clog2(WIDTH);

    localparam logic [6:0] SEG_ZERO_N = ~7'b0111111;
    localparam logic [6:0] SEG_OVF_N  = ~7'b1100011;

    typedef enum logic [1:0] {IDLE, CONVERT, UPDATE} state_t;

    logic [SYNC_STAGES-1:0] trans_sync_q, trans_sync_d;
    logic [SYNC_STAGES-1:0] clr_sync_q, clr_sync_d;
    logic                   trans_last_q, trans_last_d;
    logic                   clr_last_q, clr_last_d;
    logic                   trans_pushed_q, trans_pushed_d;
    logic                   clr_pushed_q, clr_pushed_d;

    state_t                 state_q, state_d;
    logic [WIDTH-1:0]       sh_q, sh_d;
    logic [1:0]             mode_q, mode_d;
    logic [ACCW-1:0]        acc_q, acc_d, acc_adj;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [7*DIGITS-1:0]    seg_q, seg_d;
    logic                   ovf_q, ovf_d;
    logic                   done_q, done_d;
    logic                   is_dec, is_oct, ovf_calc;

    // Hex digit to active-low segments {g,f,e,d,c,b,a}.
    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'h0: s = 7'b0111111;
            4'h1: s = 7'b0000110;
            4'h2: s = 7'b1011011;
            4'h3: s = 7'b1001111;
            4'h4: s = 7'b1100110;
            4'h5: s = 7'b1101101;
            4'h6: s = 7'b1111101;
            4'h7: s = 7'b0000111;
            4'h8: s = 7'b1111111;
            4'h9: s = 7'b1101111;
            4'hA: s = 7'b1110111;
            4'hB: s = 7'b1111100;
            4'hC: s = 7'b0111001;
            4'hD: s = 7'b1011110;
            4'hE: s = 7'b1111001;
            default: s = 7'b1110001;
        endcase
        return ~s;
    endfunction

    // Key synchronisers and single-cycle press pulses on the released->pressed edge.
    always_comb begin
        trans_sync_d   = {trans_sync_q[SYNC_STAGES-2:0], key_trans_n};
        clr_sync_d     = {clr_sync_q[SYNC_STAGES-2:0], key_clr_n};
        trans_last_d   = trans_sync_q[SYNC_STAGES-1];
        clr_last_d     = clr_sync_q[SYNC_STAGES-1];
        trans_pushed_d = trans_last_q & ~trans_sync_q[SYNC_STAGES-1];
        clr_pushed_d   = clr_last_q & ~clr_sync_q[SYNC_STAGES-1];
    end

    // Synchroniser registers; reset to the released level so reset never looks like a press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trans_sync_q   <= '1;
            clr_sync_q     <= '1;
            trans_last_q   <= 1'b1;
            clr_last_q     <= 1'b1;
            trans_pushed_q <= 1'b0;
            clr_pushed_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values; blocking here would collapse the chain.
            trans_sync_q   <= trans_sync_d;
            clr_sync_q     <= clr_sync_d;
            trans_last_q   <= trans_last_d;
            clr_last_q     <= clr_last_d;
            trans_pushed_q <= trans_pushed_d;
            clr_pushed_q   <= clr_pushed_d;
        end
    end

    // Radix decode of the captured mode and range check of the finished accumulator.
    always_comb begin
        is_dec   = (mode_q == 2'b01);
        is_oct   = (mode_q == 2'b10);
        ovf_calc = is_oct ? (|(acc_q >> (3 * DIGITS))) : (|(acc_q >> (4 * DIGITS)));
    end

    // FSM next state and datapath: capture, shift (with double dabble in decimal), display update.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned and infers a latch.
        state_d = state_q;
        sh_d    = sh_q;
        mode_d  = mode_q;
        acc_d   = acc_q;
        acc_adj = acc_q;
        cnt_d   = cnt_q;
        seg_d   = seg_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;

        if (clr_pushed_q) begin
            state_d = IDLE;
            seg_d   = {DIGITS{SEG_ZERO_N}};
            ovf_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (trans_pushed_q) begin
                        sh_d    = value;
                        mode_d  = mode;
                        acc_d   = '0;
                        cnt_d   = '0;
                        state_d = CONVERT;
                    end
                end
                CONVERT: begin
                    if (is_dec) begin
                        for (int n = 0; n < NIB; n++) begin
                            if (acc_q[4*n +: 4] >= 4'd5) begin
                                acc_adj[4*n +: 4] = acc_q[4*n +: 4] + 4'd3;
                            end
                        end
                    end
                    acc_d = ACCW'({acc_adj, sh_q[WIDTH-1]});
                    sh_d  = {sh_q[WIDTH-2:0], 1'b0};
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        state_d = UPDATE;
                    end
                end
                UPDATE: begin
                    for (int i = 0; i < DIGITS; i++) begin
                        seg_d[7*i +: 7] = ovf_calc ? SEG_OVF_N
                                        : seg7(is_oct ? {1'b0, acc_q[3*i +: 3]} : acc_q[4*i +: 4]);
                    end
                    ovf_d   = ovf_calc;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State, datapath and display registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sh_q    <= '0;
            mode_q  <= 2'b00;
            acc_q   <= '0;
            cnt_q   <= '0;
            seg_q   <= {DIGITS{SEG_ZERO_N}};
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            mode_q  <= mode_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            seg_q   <= seg_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
        end
    end

    assign seg_out  = seg_q;
    assign overflow = ovf_q;
    assign done     = done_q;
    assign busy     = (state_q != IDLE);

endmodule

// File: doc/num_syst_multi.md
Name: num_syst_multi

Overview:
Parametrised successor to the switch-to-7-segment number-system display. On a push-button event it captures a WIDTH-bit value and converts it serially, one bit per cycle, into DIGITS display digits. The radix is selectable between hex, decimal and octal. The result drives active-low 7-segment outputs, and a range overflow shows a dedicated overflow glyph. The block sits between the board switches/keys and the HEX displays.

Parameters:
WIDTH, 8, bit width of the input value (>= 3)
DIGITS, 4, number of 7-segment digits driven (>= 1)
SYNC_STAGES, 2, flop stages in each key synchroniser (>= 2)

Ports:
clk  input  1  system clock (CLOCK_50)
rst_n  input  1  asynchronous active-low reset
key_trans_n  input  1  translate push button, active-low, asynchronous to clk
key_clr_n  input  1  display-clear push button, active-low, asynchronous to clk
mode  input  2  radix select: 00 hex, 01 dec, 10 oct, 11 treated as hex
value  input  WIDTH  binary value (switches)
seg_out  output  7*DIGITS  active-low segments; digit i at [7*i+6:7*i], digit 0 least significant; bit order {g,f,e,d,c,b,a}
overflow  output  1  last conversion did not fit in DIGITS digits
busy  output  1  conversion in progress
done  output  1  one-cycle pulse when seg_out is updated

Behaviour:
- One clock domain: clk. Async active-low reset rst_n affects every register.
- Reset state:
  - seg_out: every digit = ~7'b0111111 ("0").
  - overflow = 0, busy = 0, done = 0, FSM = IDLE.
  - Synchroniser flops reset to 1 (key released).
- Keys:
  - Each key passes through SYNC_STAGES flops.
  - A registered 1-cycle pulse (trans_pushed / clr_pushed) is generated on the synchronised 1->0 transition.
  - Holding a key produces only one pulse.
- FSM states: IDLE, CONVERT, UPDATE. busy = (state != IDLE).
- IDLE:
  - On trans_pushed, latch value into shift register sh and mode into mode_q.
  - Clear accumulator acc, bit counter cnt = 0, then go to CONVERT.
- CONVERT (exactly WIDTH cycles):
  - Each cycle, shift the MSB of sh into the LSB of acc (acc <= {acc, sh[MSB]}) and shift sh left by one.
  - In dec mode only, before the shift, add 3 to every 4-bit BCD nibble of acc that is >= 5 (double dabble).
  - When cnt == WIDTH-1, go to UPDATE.
- acc width: ACCW = max(4*DIGITS, 4*(WIDTH/3+1)) bits, zero-extended as needed.
- UPDATE (1 cycle), then return to IDLE:
  - Digit i = acc[4i+3:4i] in hex/dec; acc[3i+2:3i] zero-extended to 4 bits in oct.
  - ovf = any nonzero acc bit above the top displayed digit (above 4*DIGITS for hex/dec, 3*DIGITS for oct).
  - Register overflow <= ovf and done <= 1.
  - seg_out: every digit = ~7'b1100011 if ovf, otherwise the standard hex decoding 0-F of each digit.
  - No leading-zero blanking.
- done is high only during the cycle after UPDATE.
- Latency: seg_out, overflow and done change WIDTH+2 edges after the edge where trans_pushed is registered high.
- trans_pushed outside IDLE is ignored and not queued. value/mode changes after capture do not affect the running conversion.
- clr_pushed has priority over trans_pushed and over an in-flight conversion:
  - FSM goes to IDLE, every digit shows "0", overflow = 0, done = 0.
  - The aborted conversion produces no done pulse.
- Simultaneous clr_pushed and trans_pushed: clear only, no conversion starts.
- rst_n asserted mid-conversion: immediate reset state; no done pulse after release.

Test Plan:
- Reset (WIDTH=8, DIGITS=2): rst_n low, then high -> both digits ~7'b0111111, overflow=0, busy=0, done=0.
- Dec in range: mode=01, value=8'd99, press trans -> busy for 9 cycles, done pulse at trans_pushed+10, digits "9","9" (~7'b1101111 each), overflow=0.
- Dec overflow and wider display: DIGITS=2, value=8'd100 -> both digits ~7'b1100011, overflow=1. Repeat with DIGITS=3 -> "1","0","0", overflow=0.
- Hex and oct: mode=00, value=8'hA5 -> digit0 "5", digit1 "A". mode=10, value=8'd255 with DIGITS=3 -> "7","7","3", overflow=0. Same with DIGITS=2 -> overflow=1.
- Busy and clear: second trans press during CONVERT -> ignored, exactly one done pulse. clr press mid-conversion -> digits "0", no done pulse, busy=0 next cycle.
- Async reset mid-conversion, then held key: rst_n low during CONVERT -> all outputs reset immediately, no done pulse. Holding key_trans_n low for 100 cycles -> exactly one conversion.
